dist_ram_fifo_ctrl: RTL and testbench

- Synchronous FIFO controller placed directly upstream of the 64x16 dual-port distributed RAM.
- Turns a valid/ready push stream and a valid/ready pop stream into RAM signals:
  - write enable `we`, write address `a`, write data `di`, read address `dpra`.
- Returns the RAM's asynchronous read data `dpo` as first-word-fall-through output.
- The RAM stays a separate instance; this block owns all pointer, level and flag logic.

---
 rtl/dist_ram_fifo_ctrl.sv | 138 +++++++++++++
 tb/tb_dist_ram_fifo_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dist_ram_fifo_ctrl.sv
// dist_ram_fifo_ctrl
//   FIFO controller that drives a separate 2**ADDR_WIDTH x DATA_WIDTH
//   dual-port distributed RAM. It owns the pointers, the fill level and the
//   threshold flags. It also returns the RAM's asynchronous read port as a
//   first-word-fall-through stream.
//
//   Optional build macro: DIST_RAM_FIFO_OUTREG_EN
//     When defined, a one-entry registered output stage sits between the RAM
//     read port and rd_data/rd_valid. This removes the combinational path
//     from the RAM to rd_data. It adds one cycle of latency and one word of
//     capacity.
//
// Ports
//   clk, RST          rising-edge clock, asynchronous active-high reset
//   flush             synchronous clear; overrides push and pop
//   wr_valid/ready    push handshake, wr_data is the pushed word
//   rd_valid/ready    pop handshake, rd_data is the head word
//   level             stored word count (including the output stage if built)
//   almost_full/empty registered threshold flags, aligned with level
//   ram_we/a/di       RAM write port
//   ram_dpra/dpo      RAM asynchronous read port
module dist_ram_fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned AF_LEVEL   = 56,
  parameter int unsigned AE_LEVEL   = 8
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  flush,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic [DATA_WIDTH-1:0] ram_di,
  output logic [ADDR_WIDTH-1:0] ram_dpra,
  input  logic [DATA_WIDTH-1:0] ram_dpo
);

  localparam logic [ADDR_WIDTH:0]   PTR_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH+1:0] LVL_ONE = (ADDR_WIDTH+2)'(1);
  localparam logic [ADDR_WIDTH+1:0] AF_LVL  = (ADDR_WIDTH+2)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH+1:0] AE_LVL  = (ADDR_WIDTH+2)'(AE_LEVEL);

  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic                  empty;
  logic                  ram_full;
  logic                  push;
  logic                  ram_pop;   // head word leaves the RAM
  logic                  out_pop;   // word leaves the FIFO through rd_*
  logic [ADDR_WIDTH+1:0] level_next;

  // The extra wrap bit distinguishes full from empty when the low bits match.
  assign empty    = (wr_ptr == rd_ptr);
  assign ram_full = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                    (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

  assign wr_ready = !ram_full;
  assign push     = wr_valid && wr_ready && !flush;
  assign ram_we   = push;
  assign ram_a    = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_di   = wr_data;
  assign ram_dpra = rd_ptr[ADDR_WIDTH-1:0];

`ifdef DIST_RAM_FIFO_OUTREG_EN
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;

  // Refill the stage whenever it is empty or being drained this cycle,
  // so a held rd_ready sees one word per cycle without bubbles.
  assign ram_pop  = !empty && (!out_valid || rd_ready) && !flush;
  assign out_pop  = out_valid && rd_ready && !flush;
  assign rd_valid = out_valid;
  assign rd_data  = out_data;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (ram_pop) begin
      out_valid <= 1'b1;
      out_data  <= ram_dpo;
    end else if (out_pop) begin
      out_valid <= 1'b0;
    end
  end
`else
  assign rd_valid = !empty;
  assign rd_data  = ram_dpo;
  assign out_pop  = rd_valid && rd_ready && !flush;
  assign ram_pop  = out_pop;
`endif

  // A RAM-to-stage transfer does not change level. Only words entering or
  // leaving the FIFO as a whole are counted.
  always_comb begin
    level_next = level;
    if (flush) begin
      level_next = '0;
    end else if (push && !out_pop) begin
      level_next = level + LVL_ONE;
    end else if (!push && out_pop) begin
      level_next = level - LVL_ONE;
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push)    wr_ptr <= wr_ptr + PTR_ONE;
        if (ram_pop) rd_ptr <= rd_ptr + PTR_ONE;
      end
      level        <= level_next;
      almost_full  <= (level_next >= AF_LVL);
      almost_empty <= (level_next <= AE_LVL);
    end
  end

endmodule

// File: tb/tb_dist_ram_fifo_ctrl.sv
// Testbench for dist_ram_fifo_ctrl (base build), with a behavioural 64x16
// distributed RAM attached to the controller's RAM ports.
module tb_dist_ram_fifo_ctrl;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        RST;
  logic        flush;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [15:0] rd_data;
  logic [7:0]  level;
  logic        almost_full;
  logic        almost_empty;
  logic        ram_we;
  logic [5:0]  ram_a;
  logic [15:0] ram_di;
  logic [5:0]  ram_dpra;
  logic [15:0] ram_dpo;

  logic [15:0] mem [0:63];

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_we) mem[ram_a] <= ram_di;
  assign ram_dpo = mem[ram_dpra];

  dist_ram_fifo_ctrl #(
    .ADDR_WIDTH(6),
    .DATA_WIDTH(16),
    .AF_LEVEL(56),
    .AE_LEVEL(8)
  ) dut (
    .clk(clk),
    .RST(RST),
    .flush(flush),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_data(wr_data),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .rd_data(rd_data),
    .level(level),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .ram_we(ram_we),
    .ram_a(ram_a),
    .ram_di(ram_di),
    .ram_dpra(ram_dpra),
    .ram_dpo(ram_dpo)
  );

  int          errors = 0;
  int          checks = 0;
  logic [15:0] sb [$];
  logic [6:0]  wp_m;
  logic [6:0]  rp_m;
  logic        beef_seen = 1'b0;

  typedef struct {
    int unsigned target;
    logic        af;
    logic        ae;
    logic        wr_rdy;
  } vec_t;
  vec_t tab [9];

  always @(negedge clk) if (!RST && rd_valid && rd_data == 16'hBEEF) beef_seen = 1'b1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle. Inputs are applied just after the rising edge. The
  // combinational outputs are checked at the falling edge. The registered
  // outputs are checked just after the next rising edge.
  task automatic drive_cycle(input logic fl, input logic wv, input logic [15:0] wd, input logic rr);
    int unsigned cnt;
    logic exp_wr, exp_rv, exp_we, exp_pop;
    flush = fl; wr_valid = wv; wr_data = wd; rd_ready = rr;
    cnt     = sb.size();
    exp_wr  = (cnt < DEPTH);
    exp_rv  = (cnt > 0);
    exp_we  = wv && !fl && exp_wr;
    exp_pop = exp_rv && rr && !fl;
    @(negedge clk);
    chk("wr_ready", 32'(wr_ready), 32'(exp_wr));
    chk("rd_valid", 32'(rd_valid), 32'(exp_rv));
    chk("ram_we",   32'(ram_we),   32'(exp_we));
    chk("ram_a",    32'(ram_a),    32'(wp_m[5:0]));
    chk("ram_dpra", 32'(ram_dpra), 32'(rp_m[5:0]));
    chk("ram_di",   32'(ram_di),   32'(wd));
    if (exp_rv) chk("rd_data", 32'(rd_data), 32'(sb[0]));
    if (fl) begin
      sb.delete(); wp_m = '0; rp_m = '0;
    end else begin
      if (exp_pop) begin void'(sb.pop_front()); rp_m++; end
      if (exp_we)  begin sb.push_back(wd); wp_m++; end
    end
    @(posedge clk); #1;
    chk("level",        32'(level),        32'(sb.size()));
    chk("almost_full",  32'(almost_full),  32'(sb.size() >= 56));
    chk("almost_empty", 32'(almost_empty), 32'(sb.size() <= 8));
  endtask

  initial begin
    logic [15:0] d;
    tab[0] = '{1,  1'b0, 1'b1, 1'b1};
    tab[1] = '{7,  1'b0, 1'b1, 1'b1};
    tab[2] = '{8,  1'b0, 1'b1, 1'b1};
    tab[3] = '{9,  1'b0, 1'b0, 1'b1};
    tab[4] = '{55, 1'b0, 1'b0, 1'b1};
    tab[5] = '{56, 1'b1, 1'b0, 1'b1};
    tab[6] = '{57, 1'b1, 1'b0, 1'b1};
    tab[7] = '{63, 1'b1, 1'b0, 1'b1};
    tab[8] = '{64, 1'b1, 1'b0, 1'b0};
    for (int unsigned i = 0; i < 64; i++) mem[i] = '0;

    RST = 1'b1; flush = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    wp_m = '0; rp_m = '0;
    #12;
    chk("reset_level",    32'(level),        32'd0);
    chk("reset_wr_ready", 32'(wr_ready),     32'd1);
    chk("reset_rd_valid", 32'(rd_valid),     32'd0);
    chk("reset_af",       32'(almost_full),  32'd0);
    chk("reset_ae",       32'(almost_empty), 32'd1);
    @(negedge clk); RST = 1'b0;
    @(posedge clk); #1;

    // Fill 0x0001..0x0040 with threshold checkpoints from the table.
    d = 16'h0001;
    for (int unsigned i = 0; i < 9; i++) begin
      while (sb.size() < tab[i].target) begin
        drive_cycle(1'b0, 1'b1, d, 1'b0);
        d++;
      end
      chk("tab_level",    32'(level),        32'(tab[i].target));
      chk("tab_af",       32'(almost_full),  32'(tab[i].af));
      chk("tab_ae",       32'(almost_empty), 32'(tab[i].ae));
      chk("tab_wr_ready", 32'(wr_ready),     32'(tab[i].wr_rdy));
    end
    // A 65th push must be refused.
    drive_cycle(1'b0, 1'b1, 16'h0041, 1'b0);
    // A pop while full does not let a simultaneous push in.
    drive_cycle(1'b0, 1'b1, 16'h0042, 1'b1);
    chk("full_pop_push_level", 32'(level), 32'd63);
    drive_cycle(1'b0, 1'b1, 16'h0041, 1'b0);

    // Drain everything in order.
    for (int i = 0; i < DEPTH; i++) drive_cycle(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("drained_level",    32'(level),        32'd0);
    chk("drained_rd_valid", 32'(rd_valid),     32'd0);
    chk("drained_ae",       32'(almost_empty), 32'd1);

    // Continuous streaming across three pointer wraps.
    for (int i = 0; i < 200; i++) begin
      drive_cycle(1'b0, 1'b1, 16'h1000 + 16'(i), 1'b1);
      chk("stream_level_bound", 32'(level <= 8'd1), 32'd1);
    end
    drive_cycle(1'b0, 1'b0, 16'h0000, 1'b1);

    // Flush with a push offered in the same cycle.
    for (int i = 0; i < 10; i++) drive_cycle(1'b0, 1'b1, 16'h2000 + 16'(i), 1'b0);
    drive_cycle(1'b1, 1'b1, 16'hBEEF, 1'b0);
    chk("flush_level",    32'(level),    32'd0);
    chk("flush_rd_valid", 32'(rd_valid), 32'd0);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 16'h0000, 1'b1);
    drive_cycle(1'b0, 1'b1, 16'h3000, 1'b0);
    drive_cycle(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("flush_beef_seen", 32'(beef_seen), 32'd0);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b1, 16'h4000 + 16'(i), 1'b0);
    wr_valid = 1'b1; wr_data = 16'h4100; rd_ready = 1'b1;
    #3 RST = 1'b1;
    #1;
    chk("async_rst_level",    32'(level),        32'd0);
    chk("async_rst_rd_valid", 32'(rd_valid),     32'd0);
    chk("async_rst_wr_ready", 32'(wr_ready),     32'd1);
    chk("async_rst_af",       32'(almost_full),  32'd0);
    chk("async_rst_ae",       32'(almost_empty), 32'd1);
    sb.delete(); wp_m = '0; rp_m = '0;
    #2; wr_valid = 1'b0; rd_ready = 1'b0; RST = 1'b0;
    @(posedge clk); #1;
    drive_cycle(1'b0, 1'b1, 16'h1234, 1'b0);
    chk("post_rst_rd_valid", 32'(rd_valid), 32'd1);
    chk("post_rst_rd_data",  32'(rd_data),  32'h1234);
    drive_cycle(1'b0, 1'b0, 16'h0000, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
